// File: rtl/trig_pkg.sv
// Shared types and float field helpers for the trig-evaluation stage.
package trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4
    } trig_state_e;

    localparam int unsigned DEF_EXP_LEN      = 8;
    localparam int unsigned DEF_MANTISSA_LEN = 23;
    localparam int unsigned DEF_WORD_W       = DEF_EXP_LEN + DEF_MANTISSA_LEN + 1;

    // Exponent field of a float word (word passed zero-extended to 64 bits).
    function automatic logic [63:0] exp_of(input logic [63:0] word,
                                           input int unsigned exp_len,
                                           input int unsigned mant_len);
        logic [63:0] mask;
        mask = (64'd1 << exp_len) - 64'd1;
        return (word >> mant_len) & mask;
    endfunction

    // Sign bit of a float word (word passed zero-extended to 64 bits).
    function automatic logic sign_of(input logic [63:0] word,
                                     input int unsigned exp_len,
                                     input int unsigned mant_len);
        return 1'(word >> (exp_len + mant_len));
    endfunction

    // Encoding of +1.0: sign 0, exponent = bias, mantissa 0.
    function automatic logic [63:0] fp_one(input int unsigned exp_len,
                                           input int unsigned mant_len);
        logic [63:0] bias;
        bias = (64'd1 << (exp_len - 1)) - 64'd1;
        return bias << mant_len;
    endfunction

    localparam logic [DEF_WORD_W-1:0] FP_ONE = DEF_WORD_W'(fp_one(DEF_EXP_LEN, DEF_MANTISSA_LEN));

endpackage

// File: rtl/angle_trig_eval_wrapper.sv
// Walks the normalized angle memory, evaluates cos/sin per entry through the
// shared external core (zero-exponent angles bypass it) and writes the results.
module angle_trig_eval_wrapper
    import trig_pkg::*;
#(
    parameter int unsigned EXP_LEN      = DEF_EXP_LEN,
    parameter int unsigned MANTISSA_LEN = DEF_MANTISSA_LEN,
    parameter int unsigned NUM_ANGLE    = 20,
    localparam int unsigned W = EXP_LEN + MANTISSA_LEN + 1,
    localparam int unsigned A = (NUM_ANGLE > 1) ? $clog2(NUM_ANGLE) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start_trig_eval,
    input  logic [W-1:0] mem_angle_combination_value_data_out,
    input  logic [W-1:0] trig_eval_cos,
    input  logic [W-1:0] trig_eval_sin,
    input  logic         trig_eval_ready,
    output logic [A-1:0] mem_angle_combination_value_read_addr,
    output logic [W-1:0] trig_eval_angle,
    output logic         trig_eval_start,
    output logic [A-1:0] mem_trig_write_addr,
    output logic [W-1:0] mem_cos_data_in,
    output logic [W-1:0] mem_sin_data_in,
    output logic         mem_trig_write_en,
    output logic         trig_eval_busy,
    output logic         trig_eval_done
);

    localparam logic [A-1:0] LAST_IDX = A'(NUM_ANGLE - 1);
    localparam logic [W-1:0] ONE_W    = W'(fp_one(EXP_LEN, MANTISSA_LEN));

    trig_state_e  state_q, state_d;
    logic [A-1:0] read_addr_q, read_addr_d;
    logic [A-1:0] write_addr_q, write_addr_d;
    logic [W-1:0] angle_q, angle_d;
    logic [W-1:0] cos_q, cos_d;
    logic [W-1:0] sin_q, sin_d;
    logic         start_q, start_d;
    logic         wen_q, wen_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         exp_zero_c;
    logic         sign_c;

    // Field decode of the angle word currently presented by the memory.
    always_comb begin
        exp_zero_c = (exp_of(64'(mem_angle_combination_value_data_out), EXP_LEN, MANTISSA_LEN) == 64'd0);
        sign_c     = sign_of(64'(mem_angle_combination_value_data_out), EXP_LEN, MANTISSA_LEN);
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        read_addr_d  = read_addr_q;
        write_addr_d = write_addr_q;
        angle_d      = angle_q;
        cos_d        = cos_q;
        sin_d        = sin_q;
        start_d      = 1'b0;
        wen_d        = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_trig_eval) begin
                    read_addr_d = '0;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                angle_d      = mem_angle_combination_value_data_out;
                write_addr_d = read_addr_q;
                if (exp_zero_c) begin
                    // Zero/denormal: cos = 1.0, sin = signed zero.
                    cos_d   = ONE_W;
                    sin_d   = {sign_c, (W-1)'(0)};
                    wen_d   = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    start_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (trig_eval_ready) begin
                    cos_d   = trig_eval_cos;
                    sin_d   = trig_eval_sin;
                    wen_d   = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (read_addr_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    read_addr_d = read_addr_q + A'(1);
                    state_d     = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            read_addr_q  <= '0;
            write_addr_q <= '0;
            angle_q      <= '0;
            cos_q        <= '0;
            sin_q        <= '0;
            start_q      <= 1'b0;
            wen_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_addr_q  <= read_addr_d;
            write_addr_q <= write_addr_d;
            angle_q      <= angle_d;
            cos_q        <= cos_d;
            sin_q        <= sin_d;
            start_q      <= start_d;
            wen_q        <= wen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem_angle_combination_value_read_addr = read_addr_q;
    assign trig_eval_angle                       = angle_q;
    assign trig_eval_start                       = start_q;
    assign mem_trig_write_addr                   = write_addr_q;
    assign mem_cos_data_in                       = cos_q;
    assign mem_sin_data_in                       = sin_q;
    assign mem_trig_write_en                     = wen_q;
    assign trig_eval_busy                        = busy_q;
    assign trig_eval_done                        = done_q;

endmodule
